// File: rtl/alu_pkg.sv
// Shared types for pipe_alu: op encoding, status bit positions and FSM states.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_XOR = 3'b010,
      OP_ADD = 3'b011,
      OP_SHL = 3'b100,
      OP_SHR = 3'b101,
      OP_SRA = 3'b110,
      OP_MUL = 3'b111
   } op_e;

   localparam int ST_V = 3;
   localparam int ST_C = 2;
   localparam int ST_N = 1;
   localparam int ST_Z = 0;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier. One partial-product step per clock; the
// final product is presented combinationally alongside done so the parent
// can capture it on the same edge the counter reaches zero.
module alu_mul_iter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             done,
   output logic [WIDTH-1:0] product_lo,
   output logic             product_hi_nz
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier;
   logic [CNT_W-1:0]   count;

   assign acc_next      = mplier[0] ? acc + mcand : acc;
   assign done          = (count == CNT_W'(1));
   assign product_lo    = acc_next[WIDTH-1:0];
   assign product_hi_nz = |acc_next[2*WIDTH-1:WIDTH];

   // Load operands on start, then add-and-shift once per cycle until count expires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         count  <= '0;
      end else if (start) begin
         mcand  <= {{WIDTH{1'b0}}, multiplicand};
         mplier <= multiplier;
         acc    <= '0;
         count  <= CNT_W'(WIDTH);
      end else if (count != '0) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_alu.sv
// Handshaked ALU with registered result and {V,C,N,Z} status.
// Define ALU_MUL_EN to make op 111 an iterative WIDTH-cycle multiply;
// otherwise op 111 is a single-cycle zero result.
module pipe_alu
   import alu_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [4:0]       select,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       status,
   output logic             busy
);

   op_e                op;
   state_e             state;
   logic               accept;
   logic               is_mul_op;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [WIDTH:0]     sum;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   alu_res;
   logic [3:0]         alu_st;
   logic               mul_done;
   logic               mul_hi_nz;
   logic [WIDTH-1:0]   mul_lo;

   function automatic logic [3:0] make_status(input logic [WIDTH-1:0] r,
                                              input logic v, input logic c);
      logic [3:0] s;
      s       = '0;
      s[ST_V] = v;
      s[ST_C] = c;
      s[ST_N] = r[WIDTH-1];
      s[ST_Z] = (r == '0);
      return s;
   endfunction

   assign op       = op_e'(select[4:2]);
   assign op_a     = select[0] ? ~a : a;
   assign op_b     = select[1] ? ~b : b;
   assign sum      = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
   assign shamt    = b[SHAMT_W-1:0];
   assign in_ready = !busy && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
   assign is_mul_op = (op == OP_MUL);

   alu_mul_iter #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (accept && is_mul_op),
      .multiplicand  (op_a),
      .multiplier    (op_b),
      .done          (mul_done),
      .product_lo    (mul_lo),
      .product_hi_nz (mul_hi_nz)
   );
`else
   assign is_mul_op = 1'b0;
   assign mul_done  = 1'b0;
   assign mul_hi_nz = 1'b0;
   assign mul_lo    = '0;
`endif

   // Single-cycle datapath; shifts use raw a, oversize shift amounts fall out of SV shift semantics
   always_comb begin
      alu_res = '0;
      alu_st  = '0;
      case (op)
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_ADD:  alu_res = sum[WIDTH-1:0];
         OP_SHL:  alu_res = a << shamt;
         OP_SHR:  alu_res = a >> shamt;
         OP_SRA:  alu_res = $signed(a) >>> shamt;
         default: alu_res = '0;
      endcase
      if (op == OP_ADD)
         alu_st = make_status(alu_res,
                              ~(op_a[WIDTH-1] ^ op_b[WIDTH-1]) & (sum[WIDTH-1] ^ op_a[WIDTH-1]),
                              sum[WIDTH]);
      else
         alu_st = make_status(alu_res, 1'b0, 1'b0);
   end

   // Control FSM: output register load/drain and multiply sequencing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         status    <= '0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (is_mul_op) begin
                     state <= S_MUL;
                     busy  <= 1'b1;
                  end else begin
                     result    <= alu_res;
                     status    <= alu_st;
                     out_valid <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               if (mul_done) begin
                  result    <= mul_lo;
                  status    <= make_status(mul_lo, 1'b0, mul_hi_nz);
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_alu.sv
// Testbench for pipe_alu: an 8-bit instance exercised with directed and
// random operations against a behavioural model, plus a 64-bit instance
// for wide add/subtract cases.
module tb_pipe_alu;

   localparam int W  = 8;
   localparam int SH = $clog2(W);
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         in_valid, in_ready, cin, out_valid, out_ready, busy;
   logic [W-1:0] a, b, result;
   logic [4:0]   select;
   logic [3:0]   status;

   pipe_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .select(select), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .status(status), .busy(busy)
   );

   logic        in_valid_w, in_ready_w, cin_w, out_valid_w, out_ready_w, busy_w;
   logic [63:0] a_w, b_w, result_w;
   logic [4:0]  select_w;
   logic [3:0]  status_w;

   pipe_alu #(.WIDTH(64)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
      .a(a_w), .b(b_w), .cin(cin_w), .select(select_w), .out_valid(out_valid_w),
      .out_ready(out_ready_w), .result(result_w), .status(status_w), .busy(busy_w)
   );

   int checks = 0;
   int passes = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference: returns {V,C,N,Z,result} from plain integer arithmetic.
   function automatic logic [W+3:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mc, input logic [4:0] sel);
      logic [W-1:0] ia, ib, r;
      longint unsigned ua, ub, am, full;
      longint sa, sb, sam, ssum, sr, p2;
      logic c, v;
      int sh;
      ia = sel[0] ? ~ma : ma;
      ib = sel[1] ? ~mb : mb;
      ua = ia; ub = ib; am = ma;
      sa  = (ua >= (64'd1 << (W-1))) ? longint'(ua) - (longint'(1) << W) : longint'(ua);
      sb  = (ub >= (64'd1 << (W-1))) ? longint'(ub) - (longint'(1) << W) : longint'(ub);
      sam = (am >= (64'd1 << (W-1))) ? longint'(am) - (longint'(1) << W) : longint'(am);
      sh = int'(mb[SH-1:0]);
      p2 = longint'(1) << sh;
      c = 1'b0; v = 1'b0; r = '0;
      case (sel[4:2])
         3'd0: r = W'(ua & ub);
         3'd1: r = W'(ua | ub);
         3'd2: r = W'(ua ^ ub);
         3'd3: begin
            full = ua + ub + longint'(mc);
            r    = W'(full);
            c    = (full >> W) != 0;
            ssum = sa + sb + longint'(mc);
            v    = (ssum > (longint'(1) << (W-1)) - 1) || (ssum < -(longint'(1) << (W-1)));
         end
         3'd4: r = (sh >= W) ? '0 : W'(am * longint'(p2));
         3'd5: r = (sh >= W) ? '0 : W'(am / longint'(p2));
         3'd6: begin
            sr = (sam >= 0) ? sam / p2 : -((-sam + p2 - 1) / p2);
            r  = W'(sr);
         end
         default: begin
            if (MUL_EN) begin
               full = ua * ub;
               r    = W'(full);
               c    = (full >> W) != 0;
            end
         end
      endcase
      return {v, c, r[W-1], (r == '0), r};
   endfunction

   // Issue one op with out_ready=1, check latency, busy, result and status.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic [4:0] ts, input string tag,
                         output logic [W-1:0] obs_r, output logic [3:0] obs_s);
      logic [W+3:0] exp;
      bit is_mul;
      int n;
      exp    = model(ta, tb_, tc, ts);
      is_mul = (ts[4:2] == 3'b111) && MUL_EN;
      a = ta; b = tb_; cin = tc; select = ts; in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_in_ready"}, in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tag, "_busy"}, busy, is_mul);
      n = 1;
      while (!out_valid && n < W + 10) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_latency"}, n, is_mul ? W + 1 : 1);
      chk({tag, "_result"}, result, exp[W-1:0]);
      chk({tag, "_status"}, status, exp[W+3:W]);
      obs_r = result;
      obs_s = status;
      @(posedge clk); #1;
   endtask

   logic [W-1:0] r_obs, hold_r;
   logic [3:0]   s_obs, hold_s;
   logic [W+3:0] e;
   logic [4:0]   rsel;

   initial begin
      in_valid = 0; a = '0; b = '0; cin = 0; select = '0; out_ready = 1'b1;
      in_valid_w = 0; a_w = '0; b_w = '0; cin_w = 0; select_w = '0; out_ready_w = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_result", result, '0);
      chk("rst_status", status, '0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1'b1);

      // 64-bit add overflow and subtract-to-zero
      a_w = 64'h7FFF_FFFF_FFFF_FFFF; b_w = 64'd1; cin_w = 1'b0; select_w = 5'b01100;
      in_valid_w = 1'b1;
      chk("w64_in_ready", in_ready_w, 1'b1);
      @(posedge clk); #1;
      chk("w64_add_valid", out_valid_w, 1'b1);
      chk("w64_add_result", result_w, 64'h8000_0000_0000_0000);
      chk("w64_add_status", status_w, 4'b1010);
      a_w = 64'd5; b_w = 64'd5; cin_w = 1'b1; select_w = 5'b01110;
      @(posedge clk); #1;
      in_valid_w = 1'b0;
      chk("w64_sub_valid", out_valid_w, 1'b1);
      chk("w64_sub_result", result_w, 64'd0);
      chk("w64_sub_status", status_w, 4'b0101);
      chk("w64_busy", busy_w, 1'b0);
      @(posedge clk); #1;
      chk("w64_drain", out_valid_w, 1'b0);

      // 8-bit directed shifts and subtract
      run_op(8'h90, 8'd3, 1'b0, 5'b11000, "sra", r_obs, s_obs);
      chk("sra_const_r", r_obs, 8'hF2);
      chk("sra_const_s", s_obs, 4'b0010);
      run_op(8'h90, 8'd3, 1'b0, 5'b10100, "shr", r_obs, s_obs);
      chk("shr_const_r", r_obs, 8'h12);
      chk("shr_const_s", s_obs, 4'b0000);
      run_op(8'h90, 8'd3, 1'b1, 5'b10011, "shl_inv_ignored", r_obs, s_obs);
      chk("shl_const_r", r_obs, 8'h80);
      run_op(8'd5, 8'd5, 1'b1, 5'b01110, "sub", r_obs, s_obs);
      chk("sub_const_s", s_obs, 4'b0101);

      // Backpressure: hold a result while a new bundle waits
      out_ready = 1'b0;
      a = 8'h7F; b = 8'h01; cin = 1'b0; select = 5'b01100; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_result", result, 8'h80);
      chk("bp_status", status, 4'b1010);
      hold_r = result; hold_s = status;
      a = 8'h0F; b = 8'hF0; select = 5'b00100;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_hold_r", result, hold_r);
         chk("bp_hold_s", status, hold_s);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_swap_valid", out_valid, 1'b1);
      chk("bp_swap_result", result, 8'hFF);
      chk("bp_swap_status", status, 4'b0010);
      @(posedge clk); #1;
      chk("bp_drained", out_valid, 1'b0);

      // Back-to-back single-cycle throughput
      for (int i = 0; i < 6; i++) begin
         rsel = {3'($urandom_range(0, 6)), 2'($urandom)};
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom); select = rsel;
         in_valid = 1'b1;
         e = model(a, b, cin, select);
         chk("tp_in_ready", in_ready, 1'b1);
         @(posedge clk); #1;
         chk("tp_valid", out_valid, 1'b1);
         chk("tp_result", result, e[W-1:0]);
         chk("tp_status", status, e[W+3:W]);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("tp_drained", out_valid, 1'b0);

      // Multiply (or op 111 zero result in the default build)
      run_op(8'h10, 8'h11, 1'b0, 5'b11100, "mul_hi", r_obs, s_obs);
      chk("mul_hi_r", r_obs, MUL_EN ? 8'h10 : 8'h00);
      chk("mul_hi_s", s_obs, MUL_EN ? 4'b0100 : 4'b0001);
      run_op(8'h03, 8'h05, 1'b0, 5'b11100, "mul_lo", r_obs, s_obs);
      chk("mul_lo_r", r_obs, MUL_EN ? 8'h0F : 8'h00);
      chk("mul_lo_s", s_obs, MUL_EN ? 4'b0000 : 4'b0001);

      // Random operations across all ops and invert bits
      for (int i = 0; i < 40; i++)
         run_op(W'($urandom), W'($urandom), 1'($urandom), 5'($urandom), "rand", r_obs, s_obs);

      // Reset in the middle of a multiply
      a = 8'hAB; b = 8'hCD; cin = 1'b0; select = 5'b11100; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", out_valid, 1'b0);
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_result", result, '0);
      chk("mrst_status", status, '0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mrst_in_ready", in_ready, 1'b1);
      chk("mrst_no_result", out_valid, 1'b0);
      run_op(8'h22, 8'h11, 1'b1, 5'b01100, "post_rst_add", r_obs, s_obs);
      chk("post_rst_add_r", r_obs, 8'h34);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/pipe_alu.md
# pipe_alu

Parametrised, handshaked successor to the 64-bit combinational ALU. Operands and select are accepted over a valid/ready input port. Results and registered status flags come back on a valid/ready output port. Single-cycle ops return in one clock. An optional iterative multiplier occupies the block for WIDTH cycles. It sits between the issue stage and writeback, so results no longer need to be consumed in the same cycle they are produced.

## Interface
- WIDTH, 64, operand/result width in bits; minimum 8
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from b
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block can accept this cycle
- a, b  in  WIDTH  operands
- cin  in  1  adder carry-in
- select  in  5  [1] invert b, [0] invert a, [4:2] op
- out_valid  out  1  result/status valid
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  registered result
- status  out  4  registered {V, C, N, Z}
- busy  out  1  multiply iteration in progress

## Operation
- Operand inversion: as = select[0] ? ~a : a; bs = select[1] ? ~b : b.
- Op codes on select[4:2]:
  - 000: AND of as, bs
  - 001: OR of as, bs
  - 010: XOR of as, bs
  - 011: ADD, as + bs + cin
  - 100: SHL, a << b[SHAMT_W-1:0]
  - 101: SHR, logical a >> shamt
  - 110: SRA, arithmetic a >>> shamt (new)
  - 111: MUL (macro) or zero
- Shifts use raw a and are not affected by the invert bits.
- If shamt >= WIDTH (non-power-of-2 WIDTH): SHL/SHR give 0; SRA gives all copies of a[WIDTH-1].
- Status flags:
  - N = result[WIDTH-1]
  - Z = (result == 0)
  - C = ADD carry-out
  - V = ~(as[msb]^bs[msb]) & (sum[msb]^as[msb])
  - For non-ADD ops, C = V = 0, except MUL (below).
- Accept: in_valid && in_ready. Define in_ready = !busy && (!out_valid || out_ready).
- FSM states are IDLE and MUL.
  - IDLE, accepting a non-MUL op: result, status and out_valid load on the accept edge. State stays IDLE.
  - IDLE, accepting MUL: latch as, bs; clear accumulator; count = WIDTH; go to MUL; busy = 1.
  - MUL: one radix-2 shift-add step per cycle (add multiplicand if multiplier LSB set; shift).
  - On the edge where count reaches 0: load result = low WIDTH bits of the unsigned product; C = 1 if any high product bit is nonzero; V = 0; N and Z as usual. Set out_valid and return to IDLE.
- Output drain: out_valid clears on the edge with out_ready=1, unless a new result loads on that same edge. Simultaneous drain and load leaves out_valid=1 with the new data.
- While out_valid && !out_ready, result and status hold stable and in_ready = 0.
- in_valid during MUL is ignored; the source must hold its bundle.
- Reset, including mid-MUL: state IDLE; out_valid, busy, result, status, accumulator and counter all 0; in_ready = 1 after release.

## Timing
- Non-MUL latency: 1 cycle. Accept on edge k makes out_valid visible in cycle k+1.
- Throughput is one op per cycle while out_ready stays 1.
- MUL latency: WIDTH+1 cycles from accept to out_valid.
- in_ready is low for WIDTH cycles after a MUL accept.
- All outputs are registered except in_ready, which is combinational from busy, out_valid and out_ready.

## Configuration
- ALU_MUL_EN defined: op 111 is the iterative MUL described above; busy can assert.
- ALU_MUL_EN undefined:
  - op 111 is single-cycle with result = 0, status = 4'b0001.
  - No multiplier logic is generated; busy is tied 0 and the FSM stays in IDLE.

## Structure
- Package alu_pkg holds:
  - op enum (OP_AND … OP_MUL, 3 bits)
  - status bit indices (ST_V=3, ST_C=2, ST_N=1, ST_Z=0)
  - FSM state typedef
- Sub-module alu_mul_iter holds the multiplicand/accumulator registers and counter, with start/done ports. It is instantiated only under ALU_MUL_EN.

## Test plan
- WIDTH=64, ADD: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> result 64'h8000_0000_0000_0000, status 4'b1010, one cycle later.
- SUB via select=5'b01110 with cin=1, a=5, b=5 -> result 0, status 4'b0101.
- WIDTH=8:
  - SRA a=8'h90, b=3 -> 8'hF2, status 4'b0010.
  - SHR with the same operands -> 8'h12, status 4'b0000.
- Backpressure: hold out_ready=0 after one result -> in_ready=0 and result stable for 10 cycles. Then out_ready=1 with a new op presented -> drain and accept on the same edge, and out_valid stays 1.
- ALU_MUL_EN, WIDTH=8:
  - 8'h10*8'h11 -> result 8'h10, C=1, out_valid 9 cycles after accept.
  - 8'h03*8'h05 -> 8'h0F, C=0.
- Assert rst_n low at cycle 4 of a MUL -> all outputs 0 immediately. After release, in_ready=1 and the next ADD completes normally.
